xgriscv_lsu: RTL and testbench

- Load/store unit sitting between the single-cycle core's execute stage and the word-only data memory.
- Acts as the initiator on the data-memory port: asynchronous word read, word write on posedge when write-enable is high.
- Handles byte and halfword loads with sign or zero extension.
- Performs byte and halfword stores as a two-cycle read-modify-write, stalling the core via req_ready.

---
 rtl/xgriscv_lsu.sv | 175 +++++++++++++++++
 tb/tb_xgriscv_lsu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xgriscv_lsu.sv
// Load/store unit between the execute stage and a word-only data memory; sub-word stores are read-modify-write.
// Define XGRISCV_LSU_MISALIGN_CHECK_EN to reject misaligned H/HU/W requests with a misalign pulse.
module xgriscv_lsu #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [ADDR_SIZE-1:0] req_pc,
  output logic                 req_ready,
  output logic                 load_valid,
  output logic [XLEN-1:0]      load_data,
  output logic                 misalign,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_a,
  output logic [XLEN-1:0]      mem_wd,
  output logic [ADDR_SIZE-1:0] mem_pc,
  input  logic [XLEN-1:0]      mem_rd
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RESP = 2'd1,
    ST_MERGE  = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t state, state_nxt;

  logic                 accept;
  logic                 f3_ok;
  logic                 mis_req;
  logic                 capture_load;
  logic                 capture_store;

  logic [XLEN-1:0]      lane_q;
  logic [2:0]           lane_f3_q;
  logic [1:0]           lane_off_q;

  logic [XLEN-1:0]      merge_q;
  logic [ADDR_SIZE-1:0] st_addr_q;
  logic [ADDR_SIZE-1:0] st_pc_q;
  logic [15:0]          st_wdata_q;
  logic                 st_half_q;
  logic [XLEN-1:0]      merged_wd;

  function automatic logic [XLEN-1:0] extend_lane(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      f3,
                                                  input logic [1:0]      off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    r = {{(XLEN-8){b[7]}}, b};
      F3_BU:   r = {{(XLEN-8){1'b0}}, b};
      F3_H:    r = {{(XLEN-16){h[15]}}, h};
      F3_HU:   r = {{(XLEN-16){1'b0}}, h};
      F3_W:    r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign f3_ok     = !(req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);

`ifdef XGRISCV_LSU_MISALIGN_CHECK_EN
  logic mis_q;

  assign mis_req = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= accept && mis_req;
  end

  assign misalign = mis_q;
`else
  assign mis_req  = 1'b0;
  assign misalign = 1'b0;
`endif

  // Replace the addressed byte or halfword of the captured word with the latched store data.
  always_comb begin
    merged_wd = merge_q;
    if (st_half_q) merged_wd[{st_addr_q[1], 4'b0000} +: 16] = st_wdata_q;
    else           merged_wd[{st_addr_q[1:0], 3'b000} +: 8] = st_wdata_q[7:0];
  end

  always_comb begin
    state_nxt     = state;
    mem_we        = 1'b0;
    mem_a         = XLEN'({req_addr[ADDR_SIZE-1:2], 2'b00});
    mem_pc        = req_pc;
    mem_wd        = req_wdata;
    capture_load  = 1'b0;
    capture_store = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !mis_req) begin
          if (!req_we) begin
            capture_load = 1'b1;
            state_nxt    = LOAD_RESP;
          end else if (f3_ok) begin
            if (req_funct3[1:0] == 2'b10) begin
              mem_we = 1'b1;
            end else begin
              capture_store = 1'b1;
              state_nxt     = ST_MERGE;
            end
          end
        end
      end
      LOAD_RESP: state_nxt = IDLE;
      ST_MERGE: begin
        mem_we    = 1'b1;
        mem_a     = XLEN'({st_addr_q[ADDR_SIZE-1:2], 2'b00});
        mem_pc    = st_pc_q;
        mem_wd    = merged_wd;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset suppresses any write in flight, including the merge write.
    if (reset) begin
      mem_we    = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q     <= '0;
      lane_f3_q  <= 3'b000;
      lane_off_q <= 2'b00;
    end else if (capture_load) begin
      lane_q     <= mem_rd;
      lane_f3_q  <= req_funct3;
      lane_off_q <= req_addr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (capture_store) begin
      merge_q    <= mem_rd;
      st_addr_q  <= req_addr;
      st_pc_q    <= req_pc;
      st_wdata_q <= req_wdata[15:0];
      st_half_q  <= req_funct3[0];
    end
  end

  assign load_valid = (state == LOAD_RESP);
  assign load_data  = (state == LOAD_RESP) ? extend_lane(lane_q, lane_f3_q, lane_off_q) : '0;

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Bench for xgriscv_lsu: a word memory behind the LSU and a byte-level reference model of loads and stores.
`timescale 1ns/1ps
module tb_xgriscv_lsu;

`ifdef XGRISCV_LSU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_pc;
  logic [31:0] mem_rd;

  logic [31:0] dmem    [0:255];
  logic [31:0] ref_mem [0:255];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xgriscv_lsu #(.XLEN(32), .ADDR_SIZE(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .req_ready  (req_ready),
    .load_valid (load_valid),
    .load_data  (load_data),
    .misalign   (misalign),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_pc     (mem_pc),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = dmem[mem_a[9:2]];

  always @(posedge clk) begin
    if (mem_we) dmem[mem_a[9:2]] <= mem_wd;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mis(input bit [2:0] f3, input bit [31:0] a);
    return MIS_EN && ((((f3 == 3'd1) || (f3 == 3'd5)) && (a % 2 == 1)) ||
                      ((f3 == 3'd2) && (a % 4 != 0)));
  endfunction

  // Expected load result from byte arithmetic on the reference word.
  function automatic logic [31:0] model_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] w);
    int unsigned off = a % 4;
    int unsigned b   = (w >> (8 * off)) % 256;
    int unsigned h   = (w >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return w;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input bit [2:0] f3, input bit [31:0] a,
                                              input bit [31:0] w, input bit [31:0] d);
    int unsigned off = a % 4;
    int unsigned sh;
    int unsigned mask;
    if (f3 == 3'd0) begin sh = 8 * off;        mask = 255;   end
    else            begin sh = 16 * (off / 2); mask = 65535; end
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  // One request from IDLE; returns 1 time unit after the posedge that ends it.
  task automatic do_op(input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] d, input bit [31:0] pc, input bit rst_in_merge);
    bit          mis = is_mis(f3, a);
    int          idx = int'(a[9:2]);
    bit [31:0]   aw  = {a[31:2], 2'b00};
    bit          sw  = we && (f3 == 3'd2);
    bit          sub = we && ((f3 == 3'd0) || (f3 == 3'd1));
    logic [31:0] old = ref_mem[idx];
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    req_pc     = pc;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_load_valid", 32'(load_valid), 32'd0);
    check("idle_misalign", 32'(misalign), 32'd0);
    check("idle_mem_a", mem_a, aw);
    check("idle_mem_pc", mem_pc, pc);
    check("accept_mem_we", 32'(mem_we), 32'(sw && !mis));
    if (sw && !mis) check("sw_mem_wd", mem_wd, d);
    @(posedge clk); #1;
    if (mis) begin
      req_valid = 1'b0;
      @(negedge clk);
      check("mis_pulse", 32'(misalign), 32'd1);
      check("mis_no_load", 32'(load_valid), 32'd0);
      check("mis_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end else if (!we) begin
      req_valid = 1'b0;
      @(negedge clk);
      check("load_valid", 32'(load_valid), 32'd1);
      check("load_data", load_data, model_load(f3, a, old));
      check("load_no_mis", 32'(misalign), 32'd0);
      check("load_ready_low", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end else if (sub) begin
      if (rst_in_merge) reset = 1'b1;
      @(negedge clk);
      check("merge_ready_low", 32'(req_ready), 32'd0);
      if (rst_in_merge) begin
        check("merge_reset_we", 32'(mem_we), 32'd0);
      end else begin
        check("merge_we", 32'(mem_we), 32'd1);
        check("merge_wd", mem_wd, model_store(f3, a, old, d));
        check("merge_mem_a", mem_a, aw);
        check("merge_mem_pc", mem_pc, pc);
        ref_mem[idx] = model_store(f3, a, old, d);
      end
      @(posedge clk); #1;
      reset     = 1'b0;
      req_valid = 1'b0;
      if (rst_in_merge) begin
        @(negedge clk);
        check("post_reset_ready", 32'(req_ready), 32'd1);
        check("post_reset_word", dmem[idx], ref_mem[idx]);
        @(posedge clk); #1;
      end
    end else begin
      req_valid = 1'b0;
      if (sw) ref_mem[idx] = d;
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_0100;
    req_wdata  = 32'hCAFE_F00D;
    req_pc     = 32'h0000_0040;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = 1'b0;

    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      if (i == 32'h40) v = 32'h8899_AABB;
      if (i == 32'h80) v = 32'h1122_3344;
      do_op(1'b1, 3'd2, 32'(i * 4), v, 32'h1000 + 32'(i * 4), 1'b0);
    end

    do_op(1'b0, 3'd0, 32'h103, 32'd0, 32'h2000, 1'b0);
    do_op(1'b0, 3'd4, 32'h103, 32'd0, 32'h2004, 1'b0);
    do_op(1'b0, 3'd1, 32'h102, 32'd0, 32'h2008, 1'b0);
    do_op(1'b0, 3'd5, 32'h100, 32'd0, 32'h200C, 1'b0);
    do_op(1'b1, 3'd0, 32'h201, 32'hFF, 32'h2010, 1'b0);
    do_op(1'b1, 3'd2, 32'h300, 32'hDEAD_BEEF, 32'h2014, 1'b0);
    do_op(1'b0, 3'd2, 32'h300, 32'd0, 32'h2018, 1'b0);
    do_op(1'b1, 3'd1, 32'h202, 32'h5566, 32'h201C, 1'b1);
    do_op(1'b0, 3'd2, 32'h101, 32'd0, 32'h2020, 1'b0);
    do_op(1'b0, 3'd2, 32'h100, 32'd0, 32'h2024, 1'b0);

    for (int i = 0; i < 200; i++) begin
      bit        we;
      bit [2:0]  f3;
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      do_op(we, f3, 32'($urandom_range(0, 1023)), $urandom, $urandom, 1'b0);
    end

    @(negedge clk);
    for (int i = 0; i < 256; i++) check($sformatf("final_word_%0d", i), dmem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
